// File: rtl/pipeline_credit_drain.sv
// Issue/collect wrapper for a stall-free fixed-latency pipeline: credits cap in-flight work at DEPTH,
// results land in a circular FIFO drained with ready/valid. Optional sticky ovf_err via PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN.
module pipeline_credit_drain #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] pipe_x,
  output logic             pipe_input_valid,
  input  logic [WIDTH-1:0] pipe_out,
  input  logic             pipe_output_valid,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_valid,
  input  logic             dn_ready
`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
  ,
  output logic             ovf_err
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (LATENCY < 1 || DEPTH < 2) begin : g_param_check
    $error("pipeline_credit_drain: LATENCY must be >= 1 and DEPTH >= 2");
  end

  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             issue, pop, push;

  // up_ready only looks at registered credit state, so dn_ready never reaches it combinationally.
  assign up_ready         = (outstanding_q != FULL);
  assign pipe_x           = up_data;
  assign pipe_input_valid = issue;
  assign dn_valid         = (count_q != '0);
  assign dn_data          = mem_q[rd_ptr_q];

  always_comb begin
    issue = up_valid & up_ready;
    pop   = dn_valid & dn_ready;
    push  = pipe_output_valid & (count_q != FULL);

    outstanding_d = outstanding_q;
    if (issue && !pop) begin
      outstanding_d = outstanding_q + ONE;
    end else if (pop && !issue && outstanding_q != '0) begin
      outstanding_d = outstanding_q - ONE;
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE;
    end else if (pop && !push) begin
      count_d = count_q - ONE;
    end

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage is deliberately unreset; dn_valid gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pipe_out;
    end
  end

`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q
          | (pipe_output_valid & (count_q == FULL))
          | (pop & (outstanding_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_pipeline_credit_drain.sv
// Bench for pipeline_credit_drain (LATENCY=1, DEPTH=4): an external +1 pipeline model feeds the DUT,
// and a queue-based reference tracks credits, FIFO contents and pointer positions.
`timescale 1ns/1ps
module tb_pipeline_credit_drain;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] up_data;
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] pipe_x;
  logic         pipe_input_valid;
  logic [W-1:0] pipe_out;
  logic         pipe_output_valid;
  logic [W-1:0] dn_data;
  logic         dn_valid;
  logic         dn_ready;
`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
  logic         ovf_err;
`endif

  pipeline_credit_drain #(.WIDTH(W), .LATENCY(1), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .pipe_x(pipe_x), .pipe_input_valid(pipe_input_valid),
    .pipe_out(pipe_out), .pipe_output_valid(pipe_output_valid),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready)
`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
    , .ovf_err(ovf_err)
`endif
  );

  always #5 clk = ~clk;

  // External single-stage pipeline computing operand+1, with an override for overflow injection.
  logic         pv_q;
  logic [W-1:0] pd_q;
  logic         frc_v = 1'b0;
  logic [W-1:0] frc_d = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= 1'b0;
      pd_q <= '0;
    end else begin
      pv_q <= pipe_input_valid;
      pd_q <= pipe_x + 32'd1;
    end
  end
  assign pipe_output_valid = pv_q | frc_v;
  assign pipe_out          = frc_v ? frc_d : pd_q;

  // Reference model: results waiting downstream, credits in use, totals of pushes/pops.
  logic [W-1:0] m_fifo[$];
  int           m_out;
  int           m_pushes;
  int           m_pops;
  logic         m_stage_v;
  logic [W-1:0] m_stage_d;
  logic         m_last_issue;
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic model_reset();
    m_fifo.delete();
    m_out = 0; m_pushes = 0; m_pops = 0;
    m_stage_v = 1'b0; m_stage_d = '0; m_last_issue = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic r);
    up_valid = v; up_data = d; dn_ready = r;
    #1;
  endtask

  task automatic advance();
    logic iss, pp, arr, was_full;
    logic [W-1:0] arr_d, nd;
    iss = up_valid && (m_out != D);
    pp = (m_fifo.size() != 0) && dn_ready;
    arr = m_stage_v || frc_v;
    arr_d = frc_v ? frc_d : m_stage_d;
    nd = up_data + 32'd1;
    was_full = (m_fifo.size() == D);
    @(posedge clk);
    if (pp) begin
      void'(m_fifo.pop_front());
      m_pops++;
    end
    if (arr && !was_full) begin
      m_fifo.push_back(arr_d);
      m_pushes++;
    end
    m_out = m_out + int'(iss) - int'(pp);
    m_stage_v = iss;
    m_stage_d = nd;
    m_last_issue = iss;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    set_in(1'b0, '0, 1'b1);
    while ((m_fifo.size() != 0 || m_stage_v || m_out != 0) && guard < 20) begin
      advance();
      guard++;
    end
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL drain_timeout: fifo=%0d outstanding=%0d required empty", m_fifo.size(), m_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frc_v = 1'b0;
    set_in(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL rst_up_ready: got %b want 1", up_ready); end
    n_cmp++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dn_valid: got %b want 0", dn_valid); end
    n_cmp++; if (pipe_input_valid !== 1'b0) begin n_fail++; $display("FAIL rst_piv: got %b want 0", pipe_input_valid); end
    n_cmp++; if (32'(dut.outstanding_q) !== 32'd0 || 32'(dut.count_q) !== 32'd0)
      begin n_fail++; $display("FAIL rst_counters: got out=%0d cnt=%0d want 0 0", dut.outstanding_q, dut.count_q); end
    n_cmp++; if (32'(dut.rd_ptr_q) !== 32'd0 || 32'(dut.wr_ptr_q) !== 32'd0)
      begin n_fail++; $display("FAIL rst_ptrs: got rd=%0d wr=%0d want 0 0", dut.rd_ptr_q, dut.wr_ptr_q); end
`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
    n_cmp++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf_err); end
`endif
  endtask

  task automatic test_single();
    set_in(1'b1, 32'h5, 1'b1);
    n_cmp++; if (pipe_x !== 32'h5 || pipe_input_valid !== 1'b1)
      begin n_fail++; $display("FAIL single_issue: got x=%0h v=%b want 5 1", pipe_x, pipe_input_valid); end
    advance();
    set_in(1'b0, '0, 1'b1);
    n_cmp++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got dn_valid=%b want 0", dn_valid); end
    advance();
    n_cmp++; if (dn_valid !== 1'b1 || dn_data !== 32'h6)
      begin n_fail++; $display("FAIL single_result: got v=%b d=%0h want 1 6", dn_valid, dn_data); end
    n_cmp++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL single_up_ready: got %b want 1", up_ready); end
    advance();
    n_cmp++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped: got dn_valid=%b want 0", dn_valid); end
  endtask

  task automatic test_back_to_back();
    int got, maxo;
    logic [W-1:0] exp_d;
    got = 0; maxo = 0; exp_d = 32'd1;
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, W'(i), 1'b1);
      n_cmp++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_drop: i=%0d got %b want 1", i, up_ready); end
      if (dn_valid === 1'b1) begin
        n_cmp++; if (dn_data !== exp_d) begin n_fail++; $display("FAIL stream_data: got %0h want %0h", dn_data, exp_d); end
        exp_d++; got++;
      end
      advance();
      if (int'(dut.outstanding_q) > maxo) maxo = int'(dut.outstanding_q);
    end
    set_in(1'b0, '0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (dn_valid === 1'b1) begin
        n_cmp++; if (dn_data !== exp_d) begin n_fail++; $display("FAIL stream_data: got %0h want %0h", dn_data, exp_d); end
        exp_d++; got++;
      end
      advance();
    end
    n_cmp++; if (got != 100) begin n_fail++; $display("FAIL stream_count: got %0d want 100", got); end
    n_cmp++; if (maxo > 2) begin n_fail++; $display("FAIL stream_outstanding: got max %0d want <=2", maxo); end
    drain();
  endtask

  task automatic test_stall();
    int acc;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, 32'h100 + W'(acc), 1'b0);
      n_cmp++; if (up_ready !== (k < 4)) begin n_fail++; $display("FAIL stall_ready: k=%0d got %b want %b", k, up_ready, k < 4); end
      if (pipe_input_valid === 1'b1) acc++;
      advance();
    end
    n_cmp++; if (acc != 4) begin n_fail++; $display("FAIL stall_accepted: got %0d want 4", acc); end
    set_in(1'b1, 32'h104, 1'b1);
    n_cmp++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL stall_pulse_ready: got %b want 0", up_ready); end
    advance();
    set_in(1'b1, 32'h104, 1'b0);
    n_cmp++; if (up_ready !== 1'b1 || pipe_input_valid !== 1'b1)
      begin n_fail++; $display("FAIL stall_reissue: got rdy=%b piv=%b want 1 1", up_ready, pipe_input_valid); end
    advance();
    set_in(1'b0, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (m_fifo.size() != 0) begin
        n_cmp++; if (dn_valid !== 1'b1 || dn_data !== m_fifo[0])
          begin n_fail++; $display("FAIL stall_drain: got v=%b d=%0h want 1 %0h", dn_valid, dn_data, m_fifo[0]); end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_simultaneous();
    int wraps, prd, pwr;
    wraps = 0;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, $urandom, 1'b0);
      advance();
    end
    for (int k = 0; k < 6; k++) begin
      prd = int'(dut.rd_ptr_q);
      pwr = int'(dut.wr_ptr_q);
      set_in(1'b1, $urandom, 1'b1);
      n_cmp++; if (dn_data !== m_fifo[0]) begin n_fail++; $display("FAIL simul_data: got %0h want %0h", dn_data, m_fifo[0]); end
      advance();
      n_cmp++; if (32'(dut.count_q) !== 32'd2 || 32'(dut.outstanding_q) !== 32'd3)
        begin n_fail++; $display("FAIL simul_counts: got cnt=%0d out=%0d want 2 3", dut.count_q, dut.outstanding_q); end
      n_cmp++; if (32'(dut.rd_ptr_q) !== 32'(m_pops % D) || 32'(dut.wr_ptr_q) !== 32'(m_pushes % D) ||
                   int'(dut.rd_ptr_q) != (prd + 1) % D || int'(dut.wr_ptr_q) != (pwr + 1) % D)
        begin n_fail++; $display("FAIL simul_ptrs: got rd=%0d wr=%0d want %0d %0d", dut.rd_ptr_q, dut.wr_ptr_q, m_pops % D, m_pushes % D); end
      if (prd == D - 1 && dut.rd_ptr_q == '0) wraps++;
    end
    n_cmp++; if (wraps == 0) begin n_fail++; $display("FAIL simul_wrap: got %0d rd wraps want >0", wraps); end
    drain();
  endtask

  task automatic test_random();
    logic v, r;
    logic [W-1:0] d;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = $urandom;
      set_in(v, d, r);
      n_cmp++; if (up_ready !== (m_out != D) || pipe_input_valid !== (v && m_out != D))
        begin n_fail++; $display("FAIL rand_issue: c=%0d got rdy=%b piv=%b want %b %b", c, up_ready, pipe_input_valid, m_out != D, v && m_out != D); end
      n_cmp++; if (dn_valid !== (m_fifo.size() != 0))
        begin n_fail++; $display("FAIL rand_dn_valid: c=%0d got %b want %b", c, dn_valid, m_fifo.size() != 0); end
      if (m_fifo.size() != 0) begin
        n_cmp++; if (dn_data !== m_fifo[0]) begin n_fail++; $display("FAIL rand_data: c=%0d got %0h want %0h", c, dn_data, m_fifo[0]); end
      end
      advance();
      n_cmp++; if (32'(dut.count_q) !== 32'(m_fifo.size()) || 32'(dut.outstanding_q) !== 32'(m_out))
        begin n_fail++; $display("FAIL rand_state: got cnt=%0d out=%0d want %0d %0d", dut.count_q, dut.outstanding_q, m_fifo.size(), m_out); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'h50 + W'(k), 1'b0);
      advance();
    end
    set_in(1'b0, '0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (dn_valid !== 1'b0 || up_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_async: got v=%b rdy=%b want 0 1", dn_valid, up_ready); end
    n_cmp++; if (32'(dut.outstanding_q) !== 32'd0 || 32'(dut.count_q) !== 32'd0)
      begin n_fail++; $display("FAIL rstmid_counters: got out=%0d cnt=%0d want 0 0", dut.outstanding_q, dut.count_q); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_in(1'b1, 32'hABC, 1'b1);
    advance();
    set_in(1'b0, '0, 1'b1);
    advance();
    n_cmp++; if (dn_valid !== 1'b1 || dn_data !== 32'hABD)
      begin n_fail++; $display("FAIL rstmid_first: got v=%b d=%0h want 1 abd", dn_valid, dn_data); end
    drain();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, $urandom, 1'b0);
      advance();
    end
    set_in(1'b0, '0, 1'b0);
    advance();
    frc_v = 1'b1;
    frc_d = 32'hDEADBEEF;
    advance();
    frc_v = 1'b0;
    #1;
    n_cmp++; if (32'(dut.count_q) !== 32'd4 || 32'(dut.outstanding_q) !== 32'd4 || 32'(dut.wr_ptr_q) !== 32'(m_pushes % D))
      begin n_fail++; $display("FAIL ovf_state: got cnt=%0d out=%0d wr=%0d want 4 4 %0d", dut.count_q, dut.outstanding_q, dut.wr_ptr_q, m_pushes % D); end
`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
    n_cmp++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
`endif
    set_in(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (dn_valid !== 1'b1 || dn_data !== m_fifo[0])
        begin n_fail++; $display("FAIL ovf_contents: got v=%b d=%0h want 1 %0h", dn_valid, dn_data, m_fifo[0]); end
      advance();
    end
    n_cmp++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got dn_valid=%b want 0", dn_valid); end
`ifdef PIPELINE_CREDIT_DRAIN_OVF_CHECK_EN
    n_cmp++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
`endif
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
